// File: rtl/baud_pkg.sv
// Shared constants and divider helpers for the baud-rate generator.
package baud_pkg;

    localparam int CLK_FREQ_DEFAULT = 100_000_000;
    localparam int BAUD_DEFAULT     = 115200;

    // Integer division rounded to the nearest whole count.
    function automatic int calc_div(longint clk, longint rate);
        return int'((clk + rate / 2) / rate);
    endfunction

    function automatic int cnt_width(int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Single-cycle strobe generator: integer divide-by-DIV, or a phase accumulator
// (INC/MOD) when BAUD_GEN_FRAC_EN is defined.
module tick_divider
    import baud_pkg::*;
#(
`ifdef BAUD_GEN_FRAC_EN
    parameter int INC = 1,
    parameter int MOD = 2
`else
    parameter int DIV = 2
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic strobe
);

`ifdef BAUD_GEN_FRAC_EN
    localparam int AW = cnt_width(MOD) + 1;
    localparam logic [AW:0] INC_W = (AW + 1)'(INC);
    localparam logic [AW:0] MOD_W = (AW + 1)'(MOD);

    logic [AW-1:0] acc;
    logic [AW:0]   sum;

    // One extra bit so acc+INC never overflows before the compare.
    assign sum = {1'b0, acc} + INC_W;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            acc    <= '0;
            strobe <= 1'b0;
        end else if (sum >= MOD_W) begin
            acc    <= AW'(sum - MOD_W);
            strobe <= 1'b1;
        end else begin
            acc    <= AW'(sum);
            strobe <= 1'b0;
        end
    end
`else
    localparam int W = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            strobe <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            strobe <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/baud_rate_generator.sv
// Baud and oversample tick generator for the RS-422 UART path.
// Define BAUD_GEN_FRAC_EN for exact-average fractional (phase accumulator) division.
module baud_rate_generator
    import baud_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int BAUD       = BAUD_DEFAULT,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick,
    output logic os_tick
);

    localparam int DIV    = calc_div(longint'(CLK_FREQ), longint'(BAUD));
    localparam int OS_DIV = calc_div(longint'(CLK_FREQ), longint'(BAUD) * longint'(OVERSAMPLE));

    if (DIV < 2) begin : g_bad_div
        $error("baud_rate_generator: DIV must be >= 2");
    end
    if (OS_DIV < 2) begin : g_bad_os_div
        $error("baud_rate_generator: OS_DIV must be >= 2");
    end
    if (OVERSAMPLE < 1 || OVERSAMPLE > 32) begin : g_bad_os
        $error("baud_rate_generator: OVERSAMPLE must be in 1..32");
    end

`ifdef BAUD_GEN_FRAC_EN
    tick_divider #(.INC(BAUD), .MOD(CLK_FREQ)) u_baud (
        .clk(clk), .rst(rst), .enable(enable), .strobe(tick)
    );
    tick_divider #(.INC(BAUD * OVERSAMPLE), .MOD(CLK_FREQ)) u_os (
        .clk(clk), .rst(rst), .enable(enable), .strobe(os_tick)
    );
`else
    tick_divider #(.DIV(DIV)) u_baud (
        .clk(clk), .rst(rst), .enable(enable), .strobe(tick)
    );
    tick_divider #(.DIV(OS_DIV)) u_os (
        .clk(clk), .rst(rst), .enable(enable), .strobe(os_tick)
    );
`endif

endmodule

// File: tb/tb_baud_rate_generator.sv
// Randomised check of baud_rate_generator against a run-length rate model.
module tb_baud_rate_generator;

`ifdef BAUD_GEN_FRAC_EN
    localparam longint T_INC = 115200;
    localparam longint T_MOD = 100_000_000;
    localparam longint O_INC = 115200 * 16;
    localparam longint O_MOD = 100_000_000;
`else
    localparam longint T_INC = 1;
    localparam longint T_MOD = 868;
    localparam longint O_INC = 1;
    localparam longint O_MOD = 54;
`endif

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic tick;
    logic os_tick;

    int tests = 0;
    int fails = 0;
    longint run = 0;

    baud_rate_generator dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick), .os_tick(os_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // After r consecutive enabled edges, a strobe is due whenever the ideal
    // rate r*inc/mod crosses a new whole number.
    function automatic logic exp_strobe(longint r, longint inc, longint m);
        if (r <= 0) return 1'b0;
        return ((r * inc) / m) > (((r - 1) * inc) / m);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst || !enable) run = 0;
        else run++;
        #1;
        chk("tick", tick, exp_strobe(run, T_INC, T_MOD));
        chk("os_tick", os_tick, exp_strobe(run, O_INC, O_MOD));
    endtask

    task automatic fresh();
        rst = 1'b0;
        enable = 1'b0;
        step();
    endtask

    int tq[$];
    int oq[$];
    int len;

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) begin
            step();
            chk("reset_tick", tick, 0);
            chk("reset_os_tick", os_tick, 0);
        end
        fresh();

`ifndef BAUD_GEN_FRAC_EN
        // Ten baud ticks from a clean enable.
        enable = 1'b1;
        for (int i = 1; i <= 8680; i++) begin
            step();
            if (tick) tq.push_back(i);
            if (os_tick) oq.push_back(i);
        end
        chk("tick_count", tq.size(), 10);
        for (int k = 0; k < 10; k++) chk("tick_time", tq[k], 868 * (k + 1));
        chk("os_first", oq[0], 54);
        chk("os_16_span", oq[16] - oq[0], 864);

        // Enable gap: dropped after 500 enabled edges for 100 edges.
        fresh();
        tq.delete();
        enable = 1'b1;
        for (int i = 1; i <= 1500; i++) begin
            if (i == 501) enable = 1'b0;
            if (i == 601) enable = 1'b1;
            step();
            if (tick) tq.push_back(i);
        end
        chk("gap_tick_count", tq.size(), 1);
        chk("gap_tick_time", tq[0], 1468);

        // Reset on the edge that would have produced a tick.
        fresh();
        tq.delete();
        enable = 1'b1;
        repeat (867) step();
        rst = 1'b1;
        step();
        chk("rst_suppress", tick, 0);
        rst = 1'b0;
        for (int i = 1; i <= 900; i++) begin
            step();
            if (tick) tq.push_back(i);
        end
        chk("rst_next_tick", tq[0], 868);
`else
        // Fractional build: 1000 ticks, intervals of 868 or 869.
        begin
            int bad = 0;
            int last = 0;
            enable = 1'b1;
            for (int i = 1; i <= 900000 && tq.size() < 1000; i++) begin
                step();
                if (tick) begin
                    if (tq.size() > 0 && (i - last != 868) && (i - last != 869)) bad++;
                    if (tq.size() == 0 && (i != 868) && (i != 869)) bad++;
                    tq.push_back(i);
                    last = i;
                end
            end
            chk("frac_tick_count", tq.size(), 1000);
            chk("frac_total_in_range", (last >= 868054 && last <= 868056) ? 1 : 0, 1);
            chk("frac_bad_intervals", bad, 0);
        end
`endif

        // Random enable/reset segments, every cycle checked by the model.
        for (int s = 0; s < 40; s++) begin
            enable = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 9) == 0);
            len    = rst ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 2000));
            repeat (len) step();
        end
        rst = 1'b0;
        enable = 1'b1;
        repeat (1000) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/baud_rate_generator.md
Name: baud_rate_generator

Overview:
Free-running baud-rate tick generator for the RS-422 UART path. Divides the system clock into single-cycle strobes:
- `tick` at the baud rate, used by the transmitter.
- `os_tick` at OVERSAMPLE × baud, used by the receiver.

Counting runs only while `enable` is high. Sits between the clock/reset domain and the tx/rx shift-register FSMs.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line baud rate in Hz.
- OVERSAMPLE, 16: receiver oversampling factor. Legal range 1..32.
- DIV (localparam): round(CLK_FREQ/BAUD) = 868 at defaults. Must be ≥ 2.
- OS_DIV (localparam): round(CLK_FREQ/(BAUD*OVERSAMPLE)) = 54 at defaults. Must be ≥ 2.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: when high, counters run; when low, counters are held cleared.
- tick, output, 1: registered one-cycle strobe at the baud rate.
- os_tick, output, 1: registered one-cycle strobe at the oversample rate.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on port `rst`.
- Reset values:
  - baud counter = 0, os counter = 0.
  - tick = 0, os_tick = 0.
  - rst has priority over enable.
- Baud counter, width $clog2(DIV):
  - enable=1: increments each cycle.
  - When the counter equals DIV-1, it wraps to 0 and tick is registered high for exactly that next cycle.
  - Otherwise tick = 0.
- Latency: with enable first sampled high at edge N, tick is high during the cycle following edge N+DIV-1. So the first tick appears DIV cycles after enable is asserted. Subsequent ticks come every DIV cycles (868 × 10 ns = 8.68 µs at defaults).
- os counter: identical scheme with OS_DIV, driving os_tick. The two counters are independent, are not phase-locked, and relative drift is permitted.
- enable=0:
  - Both counters synchronously clear to 0 on the next edge.
  - Both strobes are 0 from that edge.
  - A tick pending on the same edge that enable drops is suppressed.
- Re-asserting enable restarts the full DIV/OS_DIV interval from 0. There is no partial-period carry-over.
- Reset mid-count: counters clear and strobes drop on that edge. Counting resumes from 0 after rst deasserts, if enable=1.
- Strobes are never high for two consecutive cycles, because DIV and OS_DIV are ≥ 2.
- Parameter checks: elaboration fails if DIV < 2, OS_DIV < 2, or OVERSAMPLE is outside 1..32.

Optional Feature:
- Macro: BAUD_GEN_FRAC_EN.
- Defined: each divider is replaced by a phase accumulator of width $clog2(CLK_FREQ)+1.
  - Every enabled cycle, acc += INC, where INC = BAUD for tick and BAUD*OVERSAMPLE for os_tick.
  - If acc+INC ≥ CLK_FREQ: acc ← acc+INC−CLK_FREQ and the strobe fires the next cycle.
  - Long-term average rate is exact. At defaults, tick intervals are 868 or 869 cycles.
  - Reset and enable=0 clear acc to 0.
- Undefined: the integer divider described above; the tick interval is exactly DIV.
- Port list is identical in both builds.

Decomposition:
- Package `baud_pkg`:
  - Default constants CLK_FREQ_DEFAULT and BAUD_DEFAULT.
  - Function `calc_div(clk, rate)` implementing round-to-nearest.
  - Function `cnt_width(div)`.
- One sub-module, `tick_divider`, parameterised by divisor (or INC/MOD under BAUD_GEN_FRAC_EN). It is instantiated twice: once for tick, once for os_tick.

Test Plan:
- rst=1 for 3 cycles with enable=1 -> tick=0, os_tick=0, counters 0 throughout.
- Release rst, then enable 0→1 at cycle 0 -> first tick at cycle 868, then every 868 cycles. Check 10 ticks, each exactly 1 cycle wide.
- enable=1 -> os_tick every 54 cycles; 16 consecutive os_ticks span 864 cycles.
- enable dropped at cycle 500 and re-raised at cycle 600 -> no tick in between; next tick at cycle 1468.
- rst pulsed at count 867 -> no tick on that edge; next tick 868 cycles after rst is released.
- BAUD_GEN_FRAC_EN build, 1000 ticks -> total cycles 868055 ±1, every interval in {868, 869}.
